// File: rtl/data_mem_dp.sv
// Two-port data memory with request/ready handshake, registered reads,
// write-first forwarding between ports and a post-reset init sweep.
module data_mem_dp #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned INIT_MODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_done,
  input  logic              req_1,
  input  logic              req_2,
  input  logic              we_1,
  input  logic              we_2,
  input  logic [ADDR_W-1:0] address_1,
  input  logic [ADDR_W-1:0] address_2,
  input  logic [DATA_W-1:0] write_data_1,
  input  logic [DATA_W-1:0] write_data_2,
  output logic              ready_1,
  output logic              ready_2,
  output logic              rvalid_1,
  output logic              rvalid_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic [DATA_W-1:0]   init_pat;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                run;
  logic                ww_conflict;
  logic                wr_1, wr_2, rd_1, rd_2;
  logic [DATA_W-1:0]   rdata_1_d, rdata_2_d;
  logic [DATA_W-1:0]   rdata_1_q, rdata_2_q;
  logic                rvalid_1_q, rvalid_2_q;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_pat   = (INIT_MODE == 1) ? DATA_W'(init_cnt_q) : '0;

    run         = (state_q == RUN);
    ww_conflict = req_1 && we_1 && req_2 && we_2 && (address_1 == address_2);
    ready_1     = run;
    ready_2     = run && !ww_conflict;

    wr_1 = req_1 && ready_1 && we_1;
    wr_2 = req_2 && ready_2 && we_2;
    rd_1 = req_1 && ready_1 && !we_1;
    rd_2 = req_2 && ready_2 && !we_2;

    // Write-first: a read sees the other port's same-cycle write to its address.
    rdata_1_d = (wr_2 && (address_2 == address_1)) ? write_data_2 : mem_q[address_1];
    rdata_2_d = (wr_1 && (address_1 == address_2)) ? write_data_1 : mem_q[address_2];

    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + ADDR_W'(1);
      if (&init_cnt_q) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      rvalid_1_q <= 1'b0;
      rvalid_2_q <= 1'b0;
      rdata_1_q  <= '0;
      rdata_2_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rvalid_1_q <= rd_1;
      rvalid_2_q <= rd_2;
      if (rd_1) begin
        rdata_1_q <= rdata_1_d;
      end
      if (rd_2) begin
        rdata_2_q <= rdata_2_d;
      end
    end
  end

  // Storage carries no reset; its contents are rebuilt by the sweep instead.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[init_cnt_q] <= init_pat;
    end else begin
      if (wr_1) begin
        mem_q[address_1] <= write_data_1;
      end
      if (wr_2) begin
        mem_q[address_2] <= write_data_2;
      end
    end
  end

  assign init_done   = run;
  assign rvalid_1    = rvalid_1_q;
  assign rvalid_2    = rvalid_2_q;
  assign read_data_1 = rdata_1_q;
  assign read_data_2 = rdata_2_q;

endmodule
